// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 stream controller.
//   Word_t / State_t / Block_t : 32-bit word, 16-word core state, 512-bit keystream block
//   CHACHA_CONST               : the four "expand 32-byte k" constant words
//   CTRL_ADDR                  : core CSR control register address (pad count field)
//   CSR_*                      : controller CSR word addresses
//   ctrl_state_e               : sequencer FSM states
package chacha_pkg;

  typedef logic [31:0]     Word_t;
  typedef Word_t [15:0]    State_t;
  typedef logic [511:0]    Block_t;

  localparam Word_t CHACHA_CONST [4] = '{32'h61707865, 32'h3320646e,
                                         32'h79622d32, 32'h6b206574};

  // Core CSR map: 0-15 are the state words, 16 is the control register.
  localparam logic [5:0] CTRL_ADDR = 6'd16;

  // Controller CSR map (0-7 key words sit below CSR_COUNTER).
  localparam logic [3:0] CSR_COUNTER = 4'd8;
  localparam logic [3:0] CSR_NONCE0  = 4'd9;
  localparam logic [3:0] CSR_NONCE1  = 4'd10;
  localparam logic [3:0] CSR_NONCE2  = 4'd11;
  localparam logic [3:0] CSR_LENGTH  = 4'd12;
  localparam logic [3:0] CSR_CONTROL = 4'd13;
  localparam logic [3:0] CSR_STATUS  = 4'd14;
  localparam logic [3:0] CSR_STATS   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_STREAM,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// Bus bundle of the ChaCha20 stream controller.
//   cfg_*  : Avalon-MM CSR slave of the controller
//   core_* : Avalon-MM master towards the keystream core CSR port
//   ks_*   : Avalon-ST keystream blocks from the core
//   in_* / out_* : 32-bit Avalon-ST data in / XORed data out
//   irq    : job-complete level interrupt
// Modport slave is the controller's view; master is the surrounding system.
interface chacha_stream_ctrl_if;
  import chacha_pkg::*;

  logic         cfg_write;
  logic         cfg_read;
  logic [3:0]   cfg_address;
  Word_t        cfg_writedata;
  Word_t        cfg_readdata;
  logic         core_write;
  logic [5:0]   core_address;
  Word_t        core_writedata;
  Block_t       ks_data;
  logic         ks_valid;
  logic         ks_ready;
  Word_t        in_data;
  logic         in_valid;
  logic         in_ready;
  Word_t        out_data;
  logic         out_valid;
  logic         out_ready;
  logic         irq;

  modport slave (
    input  cfg_write, cfg_read, cfg_address, cfg_writedata,
    output cfg_readdata,
    output core_write, core_address, core_writedata,
    input  ks_data, ks_valid,
    output ks_ready,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    output irq
  );

  modport master (
    output cfg_write, cfg_read, cfg_address, cfg_writedata,
    input  cfg_readdata,
    input  core_write, core_address, core_writedata,
    output ks_data, ks_valid,
    input  ks_ready,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    input  irq
  );

endinterface

// File: rtl/chacha_ks_buffer.sv
// One-block keystream buffer and XOR output stage.
//   load/block      : capture a 512-bit keystream block (only while !full)
//   full            : a block is held and not all 16 words have been used
//   in_data/valid/ready   : input stream; a word is taken only while full
//   out_data/valid/ready  : registered XOR result, held until out_ready
module chacha_ks_buffer
  import chacha_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  Block_t block,
  output logic   full,
  input  Word_t  in_data,
  input  logic   in_valid,
  output logic   in_ready,
  output Word_t  out_data,
  output logic   out_valid,
  input  logic   out_ready
);

  Block_t     blk;
  logic [3:0] idx;
  logic       in_fire;
  Word_t      ks_word;

  assign ks_word  = blk[{idx, 5'd0} +: 32];
  // A new word may enter when the output slot is free or draining this cycle,
  // which gives back-to-back transfers with no bubble.
  assign in_ready = full && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;

  // NOTE: the block register is pure data qualified by 'full', so it carries
  // no reset; only the control flags below need a defined reset value.
  always_ff @(posedge clock) begin
    if (load) blk <= block;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full      <= 1'b0;
      idx       <= 4'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      // load only happens while empty and in_fire only while full, so the
      // two branches never compete.
      if (load) begin
        full <= 1'b1;
        idx  <= 4'd0;
      end else if (in_fire) begin
        idx <= idx + 4'd1;
        if (idx == 4'd15) full <= 1'b0;
      end

      if (in_fire) begin
        out_data  <= in_data ^ ks_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chacha_stream_ctrl.sv
// ChaCha20 stream controller: CSR bank, core sequencer and stream XOR engine.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : CSR slave, core CSR master, keystream sink, data in/out, irq
// Parameters: MAX_BURST (pads per core control write), LEN_W (length width).
// Optional build macro CHACHA_STREAM_CTRL_STATS_EN adds CSR 15, a clearable
// count of output words; without it CSR 15 reads 0 and ignores writes.
module chacha_stream_ctrl
  import chacha_pkg::*;
#(
  parameter int MAX_BURST = 32,
  parameter int LEN_W     = 16
) (
  input  logic clock,
  input  logic reset,
  chacha_stream_ctrl_if.slave bus
);

  localparam int                 BURST_W       = $clog2(MAX_BURST + 1);
  localparam logic [LEN_W-1:0]   MAX_BURST_LEN = LEN_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] MAX_BURST_B   = BURST_W'(MAX_BURST);

  // Configuration registers
  Word_t            key [8];
  Word_t            counter;
  Word_t            nonce [3];
  logic [LEN_W-1:0] length;

  // Job state
  ctrl_state_e        state, state_nxt;
  Word_t              run_ctr;
  logic [LEN_W-1:0]   remaining;
  logic [BURST_W-1:0] burst, burst_sel, blk_cnt;
  logic [3:0]         load_idx;
  logic               done_q;

  logic   busy, start_req, status_rd, set_done, burst_end, ks_fire, buf_full;
  State_t core_state;

  assign busy      = (state != ST_IDLE);
  assign start_req = bus.cfg_write && (bus.cfg_address == CSR_CONTROL) && bus.cfg_writedata[0];
  assign status_rd = bus.cfg_read && (bus.cfg_address == CSR_STATUS);
  assign burst_sel = (remaining > MAX_BURST_LEN) ? MAX_BURST_B : BURST_W'(remaining);
  assign ks_fire   = bus.ks_valid && bus.ks_ready;
  // done and irq always set and clear together, so one flag drives both.
  assign bus.irq   = done_q;

  // Initial core state image for the current reload.
  always_comb begin
    for (int i = 0; i < 4; i++) core_state[i]      = CHACHA_CONST[i];
    for (int i = 0; i < 8; i++) core_state[4 + i]  = key[i];
    core_state[12] = run_ctr;
    for (int i = 0; i < 3; i++) core_state[13 + i] = nonce[i];
  end

  // ---------------------------------------------------------------- CSRs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) key[i] <= '0;
      for (int i = 0; i < 3; i++) nonce[i] <= '0;
      counter <= '0;
      length  <= '0;
    end else if (bus.cfg_write && !busy) begin
      if (!bus.cfg_address[3]) begin
        key[bus.cfg_address[2:0]] <= bus.cfg_writedata;
      end else begin
        case (bus.cfg_address)
          CSR_COUNTER:                        counter <= bus.cfg_writedata;
          CSR_NONCE0, CSR_NONCE1, CSR_NONCE2: nonce[bus.cfg_address[1:0] - 2'd1] <= bus.cfg_writedata;
          CSR_LENGTH:                         length  <= bus.cfg_writedata[LEN_W-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef CHACHA_STREAM_CTRL_STATS_EN
  Word_t stats_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                             stats_cnt <= '0;
    else if (bus.cfg_write && bus.cfg_address == CSR_STATS) stats_cnt <= '0;
    else if (bus.out_valid && bus.out_ready)                stats_cnt <= stats_cnt + 32'd1;
  end
`endif

  always_comb begin
    bus.cfg_readdata = '0;
    if (!bus.cfg_address[3]) begin
      bus.cfg_readdata = key[bus.cfg_address[2:0]];
    end else begin
      case (bus.cfg_address)
        CSR_COUNTER:                        bus.cfg_readdata = counter;
        CSR_NONCE0, CSR_NONCE1, CSR_NONCE2: bus.cfg_readdata = nonce[bus.cfg_address[1:0] - 2'd1];
        CSR_LENGTH:                         bus.cfg_readdata = 32'(length);
        CSR_STATUS:                         bus.cfg_readdata = {30'd0, done_q, busy};
`ifdef CHACHA_STREAM_CTRL_STATS_EN
        CSR_STATS:                          bus.cfg_readdata = stats_cnt;
`endif
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt          = state;
    bus.core_write     = 1'b0;
    bus.core_address   = '0;
    bus.core_writedata = '0;
    bus.ks_ready       = 1'b0;
    set_done           = 1'b0;
    burst_end          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          if (length == '0) set_done  = 1'b1;
          else              state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bus.core_write     = 1'b1;
        bus.core_address   = {2'b00, load_idx};
        bus.core_writedata = core_state[load_idx];
        if (load_idx == 4'd15) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        bus.core_write     = 1'b1;
        bus.core_address   = CTRL_ADDR;
        bus.core_writedata = 32'(burst_sel) - 32'd1;
        state_nxt          = ST_STREAM;
      end
      ST_STREAM: begin
        // Acceptance is bounded by our own block count: the core keeps
        // ks_valid asserted after its last pad.
        bus.ks_ready = !buf_full && (blk_cnt < burst);
        if (!buf_full && blk_cnt == burst) begin
          burst_end = 1'b1;
          state_nxt = (remaining == LEN_W'(burst)) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        if (!bus.out_valid) begin
          set_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- job datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_ctr   <= '0;
      remaining <= '0;
      burst     <= '0;
      blk_cnt   <= '0;
      load_idx  <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req && length != '0) begin
            run_ctr   <= counter;
            remaining <= length;
            load_idx  <= '0;
          end
        end
        ST_LOAD: load_idx <= load_idx + 4'd1;   // wraps to 0 for the next reload
        ST_ARM: begin
          burst   <= burst_sel;
          blk_cnt <= '0;
        end
        ST_STREAM: begin
          if (ks_fire) blk_cnt <= blk_cnt + BURST_W'(1);
          if (burst_end) begin
            remaining <= remaining - LEN_W'(burst);
            run_ctr   <= run_ctr + 32'(burst);
          end
        end
        default: ;
      endcase

      if (set_done)       done_q <= 1'b1;
      else if (status_rd) done_q <= 1'b0;
    end
  end

  chacha_ks_buffer u_buffer (
    .clock     (clock),
    .reset     (reset),
    .load      (ks_fire),
    .block     (bus.ks_data),
    .full      (buf_full),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Self-checking bench for chacha_stream_ctrl. The bench plays the keystream
// core (a behavioural ChaCha20 block function fed by the controller's core
// writes) and predicts every output word directly from the programmed key,
// counter and nonce: word k of a job is in ^ ChaCha20(counter + k/16)[k%16].
module tb_chacha_stream_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  chacha_stream_ctrl_if bus ();

  chacha_stream_ctrl #(.MAX_BURST(32), .LEN_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference ChaCha20
  localparam int QR [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                               '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha_block(input logic [31:0] st [16]);
    logic [31:0]  x [16];
    logic [511:0] res;
    int a, b, c, d;
    x = st;
    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 8; q++) begin
        a = QR[q][0]; b = QR[q][1]; c = QR[q][2]; d = QR[q][3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + st[i];
    return res;
  endfunction

  logic [31:0] cfg_key [8];
  logic [31:0] cfg_ctr;
  logic [31:0] cfg_nonce [3];

  function automatic logic [31:0] ref_state_word(input int i);
    case (i)
      0: return 32'h61707865;
      1: return 32'h3320646e;
      2: return 32'h79622d32;
      3: return 32'h6b206574;
      12: return cfg_ctr;
      13, 14, 15: return cfg_nonce[i - 13];
      default: return cfg_key[i - 4];
    endcase
  endfunction

  function automatic logic [511:0] ref_block(input logic [31:0] blk_no);
    logic [31:0] st [16];
    for (int i = 0; i < 16; i++) st[i] = ref_state_word(i);
    st[12] = cfg_ctr + blk_no;
    return chacha_block(st);
  endfunction

  // ------------------------------------------------------------ core model
  logic [31:0] cs [16];
  int          pads_total = 0, pads_done = 0;
  int          ks_fires = 0, extra_fires = 0;
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];

  task automatic present_pad(input int j);
    logic [31:0] tmp [16];
    tmp = cs;
    tmp[12] = cs[12] + 32'(j);
    bus.ks_data  = chacha_block(tmp);
    bus.ks_valid = 1'b1;
  endtask

  initial begin
    logic        w, f, r;
    logic [5:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) cs[i] = '0;
    bus.ks_valid = 1'b0;
    bus.ks_data  = '0;
    forever begin
      @(negedge clock);
      w = bus.core_write; a = bus.core_address; d = bus.core_writedata;
      f = bus.ks_valid && bus.ks_ready; r = reset;
      @(posedge clock);
      #1;
      if (r || reset) continue;
      if (f) begin
        ks_fires++;
        if (pads_done >= pads_total) extra_fires++;
        else begin
          pads_done++;
          // After the last pad ks_valid stays high with the old block.
          if (pads_done < pads_total) present_pad(pads_done);
        end
      end
      if (w) begin
        log_addr.push_back(a);
        log_data.push_back(d);
        if (a < 6'd16) cs[a[3:0]] = d;
        else if (a == 6'd16) begin
          pads_total = int'(d[4:0]) + 1;
          pads_done  = 0;
          present_pad(0);
        end
      end
    end
  end

  // ------------------------------------------------------------ CSR tasks
  task automatic cfg_wr(input logic [3:0] addr, input logic [31:0] data);
    bus.cfg_address = addr; bus.cfg_writedata = data; bus.cfg_write = 1'b1;
    @(posedge clock); #1;
    bus.cfg_write = 1'b0;
  endtask

  task automatic cfg_rd(input logic [3:0] addr, output logic [31:0] data);
    bus.cfg_address = addr; bus.cfg_read = 1'b1;
    @(negedge clock);
    data = bus.cfg_readdata;
    @(posedge clock); #1;
    bus.cfg_read = 1'b0;
  endtask

  task automatic program_cfg(input int len);
    for (int i = 0; i < 8; i++) cfg_wr(4'(i), cfg_key[i]);
    cfg_wr(4'd8, cfg_ctr);
    for (int i = 0; i < 3; i++) cfg_wr(4'(9 + i), cfg_nonce[i]);
    cfg_wr(4'd12, 32'(len));
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic set_rfc();
    for (int i = 0; i < 8; i++) cfg_key[i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    cfg_ctr = 32'd1;
    cfg_nonce[0] = 32'h09000000; cfg_nonce[1] = 32'h4a000000; cfg_nonce[2] = 32'h00000000;
  endtask

  task automatic set_random(input logic [31:0] ctr);
    for (int i = 0; i < 8; i++) cfg_key[i] = $urandom;
    for (int i = 0; i < 3; i++) cfg_nonce[i] = $urandom;
    cfg_ctr = ctr;
  endtask

  logic [31:0] first_out;

  // Starts a programmed job and streams it. ready_mode: 0 always ready,
  // 1 toggling 1-0-1, 2 random. abort_at >= 0 returns (at a negedge) once
  // that many input words were taken, leaving the job running.
  task automatic run_job(input int len, input int ready_mode, input bit zero_in, input int abort_at);
    int          total, in_count, out_count, budget;
    logic [31:0] exp_q [$];
    logic [511:0] cur_ks;
    logic [31:0] prev_data, v;
    bit          irq_seen, prev_hold, aborted;
    total = len * 16; in_count = 0; out_count = 0; budget = 300 + total * 6;
    irq_seen = 0; prev_hold = 0; aborted = 0; prev_data = '0; cur_ks = '0;
    ks_fires = 0; extra_fires = 0;
    cfg_wr(4'd13, 32'd1);
    bus.in_valid  = (total > 0) && (zero_in || $urandom_range(0, 3) != 0);
    bus.in_data   = zero_in ? 32'h0 : $urandom;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clock);
      if (bus.irq && !irq_seen) begin
        irq_seen = 1;
        check("irq_after_last", 32'(out_count), 32'(total));
      end
      if (prev_hold) begin
        check("out_hold_valid", 32'(bus.out_valid), 32'd1);
        check("out_hold_data", bus.out_data, prev_data);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (out_count == 0) first_out = bus.out_data;
        if (exp_q.size() > 0) check("out_word", bus.out_data, exp_q.pop_front());
        out_count++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (in_count % 16 == 0) cur_ks = ref_block(32'(in_count / 16));
        exp_q.push_back(bus.in_data ^ cur_ks[32*(in_count % 16) +: 32]);
        in_count++;
      end
      if (abort_at >= 0 && in_count == abort_at) begin aborted = 1; break; end
      if (irq_seen) break;
      @(posedge clock); #1;
      bus.in_valid = (in_count < total) && (zero_in || $urandom_range(0, 3) != 0);
      bus.in_data  = zero_in ? 32'h0 : $urandom;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 1);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
    if (!aborted) begin
      check("out_count", 32'(out_count), 32'(total));
      check("irq_seen", 32'(irq_seen), 32'd1);
      check("ks_blocks", 32'(ks_fires), 32'(len));
      check("ks_extra", 32'(extra_fires), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check("ks_ready_idle", 32'(bus.ks_ready), 32'd0);
      end
      @(posedge clock); #1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      cfg_rd(4'd14, v);
      check("status_done", v, 32'h2);
      @(negedge clock);
      check("irq_cleared", 32'(bus.irq), 32'd0);
      @(posedge clock); #1;
    end
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_core_write"}, 32'(bus.core_write), 32'd0);
    check({tag, "_ks_ready"},   32'(bus.ks_ready),   32'd0);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, "_irq"},        32'(bus.irq),        32'd0);
    check({tag, "_out_data"},   bus.out_data,        32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ main sequence
  initial begin
    logic [31:0] v, c40;
    logic [31:0] w12 [$];
    logic [31:0] ctl [$];
    reset = 1'b1;
    bus.cfg_write = 1'b0; bus.cfg_read = 1'b0; bus.cfg_address = '0; bus.cfg_writedata = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #12;
    check_outputs_low("reset");
    #13 reset = 1'b0;
    @(posedge clock); #1;
    cfg_rd(4'd14, v);
    check("reset_status", v, 32'h0);

    // RFC 7539 2.3.2 block, in_data all zero
    set_rfc();
    program_cfg(1);
    cfg_rd(4'd8, v);
    check("cfg_counter_rb", v, 32'd1);
    run_job(1, 0, 1'b1, -1);
    check("rfc_word0", first_out, 32'he4e7f110);

    // 40 blocks: two bursts (32 + 8) with counter wrap across the reload
    c40 = 32'hFFFF_FFF0;
    set_random(c40);
    program_cfg(40);
    run_job(40, 0, 1'b0, -1);
    check("wr_total", 32'(log_addr.size()), 32'd34);
    for (int i = 0; i < 17 && i < log_addr.size(); i++) check("wr_order", 32'(log_addr[i]), 32'(i));
    for (int i = 0; i < 16 && i < log_data.size(); i++) check("wr_state", log_data[i], ref_state_word(i));
    w12.delete(); ctl.delete();
    foreach (log_addr[i]) begin
      if (log_addr[i] == 6'd12) w12.push_back(log_data[i]);
      else if (log_addr[i] == 6'd16) ctl.push_back(log_data[i]);
    end
    check("w12_count", 32'(w12.size()), 32'd2);
    check("ctrl_count", 32'(ctl.size()), 32'd2);
    if (w12.size() == 2) begin
      check("w12_first", w12[0], c40);
      check("w12_reload", w12[1], c40 + 32'd32);
    end
    if (ctl.size() == 2) begin
      check("ctrl_first", ctl[0], 32'd31);
      check("ctrl_reload", ctl[1], 32'd7);
    end

    // Length 0: immediate completion, no core traffic
    cfg_wr(4'd12, 32'd0);
    log_addr.delete(); log_data.delete();
    cfg_wr(4'd13, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (bus.irq) break;
    end
    check("len0_irq", 32'(bus.irq), 32'd1);
    @(posedge clock); #1;
    check("len0_core_writes", 32'(log_addr.size()), 32'd0);
    cfg_rd(4'd14, v);
    check("len0_status", v, 32'h2);
    @(negedge clock);
    check("len0_irq_clear", 32'(bus.irq), 32'd0);
    @(posedge clock); #1;
    cfg_rd(4'd14, v);
    check("len0_status_after", v, 32'h0);

    // Backpressure: out_ready toggling, random in_valid
    set_random($urandom);
    program_cfg(3);
    run_job(3, 1, 1'b0, -1);

    // Random backpressure
    set_random($urandom);
    program_cfg(2);
    run_job(2, 2, 1'b0, -1);

    // Reset during STREAM after word 7, then rerun the RFC block
    set_rfc();
    program_cfg(1);
    run_job(1, 0, 1'b1, 7);
    #2 reset = 1'b1;
    #1;
    check_outputs_low("midreset");
    bus.in_valid = 1'b0;
    bus.cfg_address = 4'd8;
    #1;
    check("midreset_counter_cleared", bus.cfg_readdata, 32'd0);
    @(posedge clock); @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #1;
    program_cfg(1);
    run_job(1, 0, 1'b1, -1);
    check("rfc_word0_after_reset", first_out, 32'he4e7f110);

`ifdef CHACHA_STREAM_CTRL_STATS_EN
    cfg_rd(4'd15, v);
    check("stats_count", v, 32'd16);
    cfg_wr(4'd15, 32'd5);
    cfg_rd(4'd15, v);
    check("stats_cleared", v, 32'd0);
`else
    cfg_wr(4'd15, 32'd5);
    cfg_rd(4'd15, v);
    check("stats_absent", v, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
